// File: rtl/id_lookup_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : id_lookup_ctrl
// Purpose  : Sequential ID search over a registered ID-ROM. Each entry takes a
//            FETCH cycle (ROM latency) and a COMPARE cycle. The first matching
//            entry wins; entries holding all-ones are unused and never match.
// Options  : define ID_LOOKUP_LOCKOUT_EN to add the consecutive-miss lockout
//            (MAX_FAILS misses in a row -> locked for LOCK_CYCLES cycles).
// Revision : 1.0 - initial release
// ============================================================================
module id_lookup_ctrl #(
  parameter int NUM_ENTRIES = 16,
  parameter int ADDR_W      = 4,
  parameter int MAX_FAILS   = 3,
  parameter int LOCK_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [39:0]       teclado_data,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [39:0]       rom_data,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [ADDR_W-1:0] match_index,
  output logic              locked
);

  localparam logic [39:0]       UNUSED_ID = 40'hFF_FFFF_FFFF;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_ENTRIES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_COMPARE = 3'd2,
    S_DONE    = 3'd3,
    S_LOCKED  = 3'd4
  } state_t;

  state_t      state;
  logic [39:0] id_reg;
  logic        hit;

`ifdef ID_LOOKUP_LOCKOUT_EN
  localparam int FAIL_W = $clog2(MAX_FAILS + 1);
  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);

  logic [FAIL_W-1:0] fail_cnt;
  logic [LOCK_W-1:0] lock_cnt;
`else
  // Without the lockout option the controller can never be locked.
  assign locked = 1'b0;
`endif

  // Current ROM word matches the latched ID and is not an unused slot.
  assign hit = (rom_data == id_reg) && (rom_data != UNUSED_ID);

  // Lookup sequencer with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      id_reg      <= '0;
      rom_addr    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      found       <= 1'b0;
      match_index <= '0;
`ifdef ID_LOOKUP_LOCKOUT_EN
      locked      <= 1'b0;
      fail_cnt    <= '0;
      lock_cnt    <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // IDLE is never entered while locked, so start is always honoured here.
          if (start) begin
            id_reg      <= teclado_data;
            rom_addr    <= '0;
            found       <= 1'b0;
            match_index <= '0;
            busy        <= 1'b1;
            state       <= S_FETCH;
          end
        end

        S_FETCH: begin
          state <= S_COMPARE;
        end

        S_COMPARE: begin
          if (hit) begin
            found       <= 1'b1;
            match_index <= rom_addr;
            done        <= 1'b1;
            state       <= S_DONE;
`ifdef ID_LOOKUP_LOCKOUT_EN
            fail_cnt    <= '0;
`endif
          end else if (rom_addr == LAST_ADDR) begin
            found <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
`ifdef ID_LOOKUP_LOCKOUT_EN
            fail_cnt <= fail_cnt + 1'b1;
`endif
          end else begin
            rom_addr <= rom_addr + 1'b1;
            state    <= S_FETCH;
          end
        end

        S_DONE: begin
          busy <= 1'b0;
`ifdef ID_LOOKUP_LOCKOUT_EN
          // fail_cnt already reflects this lookup (updated on the COMPARE exit).
          if (fail_cnt >= FAIL_W'(MAX_FAILS)) begin
            locked   <= 1'b1;
            lock_cnt <= '0;
            state    <= S_LOCKED;
          end else begin
            state <= S_IDLE;
          end
`else
          state <= S_IDLE;
`endif
        end

        S_LOCKED: begin
`ifdef ID_LOOKUP_LOCKOUT_EN
          if (lock_cnt == LOCK_W'(LOCK_CYCLES - 1)) begin
            locked   <= 1'b0;
            fail_cnt <= '0;
            state    <= S_IDLE;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
`else
          state <= S_IDLE;
`endif
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
